store_buffer: RTL

Posted-write buffer between the single-cycle RISC-V core's data port and data memory. Accepts word stores from the core in one cycle, queues them in a FIFO, and drains them to memory over a valid/ready handshake, so slow memory writes do not stretch the core's cycle. Core loads read memory combinationally; the youngest matching queued store is forwarded so that loads always return program-order data.

---
 rtl/store_buffer_pkg.sv | 31 +++
 rtl/store_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
//   Shared defaults and derived-width helpers for the posted-write store
//   buffer that sits between the core data port and data memory.
//   - SB_DEPTH_DEF : default number of queued stores (power of two, 2..16)
//   - SB_AW_DEF    : default byte-address width
//   - sb_ptr_width : pointer width for a given depth (log2(depth))
//   - sb_idx_width : word-index width for a given byte-address width
// -----------------------------------------------------------------------------
package store_buffer_pkg;

    localparam int SB_DEPTH_DEF = 4;
    localparam int SB_AW_DEF    = 32;

    // Pointer width; a depth below 2 still needs one pointer bit.
    function automatic int sb_ptr_width(input int depth);
        int w;
        if (depth <= 2) begin
            w = 1;
        end else begin
            w = $clog2(depth);
        end
        return w;
    endfunction

    // Stores are whole words, so the two byte-offset bits are dropped.
    function automatic int sb_idx_width(input int aw);
        return aw - 2;
    endfunction

endpackage

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Posted-write buffer between the core data port and data memory. Word
//   stores are accepted in one cycle into a circular FIFO and drained to
//   memory over a valid/ready handshake. Loads read memory combinationally;
//   the youngest queued store to the same word is forwarded instead so the
//   core always observes program-order data.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (discards queued stores)
//   core_we    in   core store request this cycle
//   core_addr  in   byte address from core (load and store)
//   core_wdata in   store data from core
//   core_rdata out  load data (forwarded store data or mem_rdata)
//   stall      out  store not accepted this cycle (buffer full)
//   empty      out  no stores queued
//   mem_valid  out  oldest queued store presented to memory
//   mem_ready  in   memory accepts the presented store
//   mem_waddr  out  word-aligned address of oldest queued store
//   mem_wdata  out  data of oldest queued store
//   mem_raddr  out  load address to memory read port (= core_addr)
//   mem_rdata  in   combinational memory read data
// -----------------------------------------------------------------------------
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF,
    parameter int AW    = SB_AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [31:0]   core_wdata,
    output logic [31:0]   core_rdata,
    output logic          stall,
    output logic          empty,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rdata
);

    localparam int PTRW = sb_ptr_width(DEPTH);
    localparam int IW   = sb_idx_width(AW);

    localparam logic [PTRW:0]   COUNT_FULL = (PTRW + 1)'(DEPTH);
    localparam logic [PTRW:0]   COUNT_ZERO = {(PTRW + 1){1'b0}};
    localparam logic [PTRW:0]   COUNT_ONE  = (PTRW + 1)'(1'b1);
    localparam logic [PTRW-1:0] PTR_ONE    = PTRW'(1'b1);

    // Entry storage (never reset: only entries below count are meaningful).
    logic [IW-1:0]   entry_addr_q [DEPTH];
    logic [IW-1:0]   entry_addr_d [DEPTH];
    logic [31:0]     entry_data_q [DEPTH];
    logic [31:0]     entry_data_d [DEPTH];

    logic [PTRW-1:0] wr_ptr_q;
    logic [PTRW-1:0] wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q;
    logic [PTRW-1:0] rd_ptr_d;
    logic [PTRW:0]   count_q;
    logic [PTRW:0]   count_d;

    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic [IW-1:0]   core_idx_s;
    logic            fwd_hit_s;
    logic [31:0]     fwd_data_s;

    assign core_idx_s = core_addr[AW-1:2];

    // Occupancy flags and handshake qualifiers.
    // A pop in this cycle does not free a slot for a push in the same cycle,
    // so push depends only on the registered count.
    always_comb begin
        full_s  = (count_q == COUNT_FULL);
        empty_s = (count_q == COUNT_ZERO);
        push_s  = core_we & ~full_s;
        pop_s   = ~empty_s & mem_ready;
    end

    // Pointer and count next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Entry storage next-state: only the write-pointer slot changes on a push.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr_d[i] = entry_addr_q[i];
            entry_data_d[i] = entry_data_q[i];
        end
        if (push_s) begin
            entry_addr_d[wr_ptr_q] = core_idx_s;
            entry_data_d[wr_ptr_q] = core_wdata;
        end else begin
            entry_addr_d[wr_ptr_q] = entry_addr_q[wr_ptr_q];
            entry_data_d[wr_ptr_q] = entry_data_q[wr_ptr_q];
        end
    end

    // Pointer/count registers; reset discards every queued store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTRW{1'b0}};
            rd_ptr_q <= {PTRW{1'b0}};
            count_q  <= COUNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage registers (data path, no reset).
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr_q[i] <= entry_addr_d[i];
            entry_data_q[i] <= entry_data_d[i];
        end
    end

    // Forwarding search: walk the queue from oldest (age 0 at rd_ptr) to
    // youngest so the last match is the youngest store to that word. The
    // entry being popped this cycle still takes part.
    always_comb begin
        logic [PTRW-1:0] idx_v;
        fwd_hit_s  = 1'b0;
        fwd_data_s = 32'h0000_0000;
        idx_v      = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx_v = rd_ptr_q + PTRW'(k);
            if (((PTRW + 1)'(k) < count_q) && (entry_addr_q[idx_v] == core_idx_s)) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = entry_data_q[idx_v];
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    // Core-facing outputs: combinational from this cycle's inputs and state.
    always_comb begin
        stall     = core_we & full_s;
        mem_raddr = core_addr;
        if (fwd_hit_s) begin
            core_rdata = fwd_data_s;
        end else begin
            core_rdata = mem_rdata;
        end
    end

    // Memory-facing outputs: depend on registered state only, so they hold
    // steady while a presented store waits for mem_ready.
    always_comb begin
        empty     = empty_s;
        mem_valid = ~empty_s;
        mem_waddr = {entry_addr_q[rd_ptr_q], 2'b00};
        mem_wdata = entry_data_q[rd_ptr_q];
    end

endmodule
